// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the state encodings, the owner codes and the pending-response record.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_S_ARB     = 2'd0,
    ARB_S_FORCE_B = 2'd1,
    ARB_S_LOCK_B  = 2'd2
  } arb_state_t;

  localparam logic ARB_OWN_A = 1'b0;
  localparam logic ARB_OWN_B = 1'b1;

  localparam int WAIT_W = 8;

  // One beat's worth of response bookkeeping, carried across a single cycle.
  typedef struct packed {
    logic valid;
    logic owner;
    logic read;
    logic err;
  } resp_t;

endpackage

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Saturating starvation counter for port B.
// reaching_max lets the arbiter hand B the very next slot instead of one cycle late.
module arb_wait_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max,
  output logic reaching_max
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max       = (count == LIMIT);
  assign reaching_max = inc && !clr && (count == (LIMIT - 1'b1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Port A (pipeline) has priority; port B gets a forced slot after MAX_WAIT stalled cycles.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int                XLEN      = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = '0,
  parameter longint            MEM_BYTES = 4096,
  parameter int                MAX_WAIT  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_a_valid,
  input  logic                i_a_we,
  input  logic [ADDR_W-1:0]   i_a_addr,
  input  logic [XLEN-1:0]     i_a_wdata,
  input  logic [XLEN/8-1:0]   i_a_wstrb,
  output logic                o_a_ready,
  output logic                o_a_rvalid,
  output logic [XLEN-1:0]     o_a_rdata,
  output logic                o_a_err,
  input  logic                i_b_valid,
  input  logic                i_b_we,
  input  logic [ADDR_W-1:0]   i_b_addr,
  input  logic [XLEN-1:0]     i_b_wdata,
  input  logic [XLEN/8-1:0]   i_b_wstrb,
  input  logic                i_b_lock,
  output logic                o_b_ready,
  output logic                o_b_rvalid,
  output logic [XLEN-1:0]     o_b_rdata,
  output logic                o_b_err,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [XLEN-1:0]     o_mem_wdata,
  output logic [XLEN/8-1:0]   o_mem_wstrb,
  input  logic [XLEN-1:0]     i_mem_rdata,
  output logic                o_b_granted
);

  arb_state_t          state;
  logic                b_granted;
  resp_t               resp;
  logic                a_ready, b_ready, a_hs, b_hs, beat;
  logic                beat_we, beat_in_range;
  logic [ADDR_W-1:0]   beat_addr;
  logic [ADDR_W:0]     beat_off;
  logic [XLEN-1:0]     beat_wdata;
  logic [XLEN/8-1:0]   beat_wstrb;
  logic                wait_inc, wait_clr, wait_at_max, wait_reaching_max;
  logic                resp_a, resp_b;

  // Outside ARB only B is served; in ARB B needs A to be idle.
  assign a_ready = (state == ARB_S_ARB);
  assign b_ready = (state == ARB_S_ARB) ? (i_b_valid && !i_a_valid) : 1'b1;
  assign a_hs    = i_a_valid && a_ready;
  assign b_hs    = i_b_valid && b_ready;
  assign beat    = a_hs || b_hs;

  assign beat_addr  = b_hs ? i_b_addr  : i_a_addr;
  assign beat_we    = b_hs ? i_b_we    : i_a_we;
  assign beat_wdata = b_hs ? i_b_wdata : i_a_wdata;
  assign beat_wstrb = b_hs ? i_b_wstrb : i_a_wstrb;

  // One extra bit keeps addr < MEM_BASE (borrow) and the upper bound from wrapping.
  assign beat_off      = {1'b0, beat_addr} - {1'b0, MEM_BASE};
  assign beat_in_range = !beat_off[ADDR_W] && (65'(beat_off) < 65'(MEM_BYTES));

  assign o_mem_en    = beat && beat_in_range;
  assign o_mem_we    = o_mem_en && beat_we;
  assign o_mem_addr  = beat ? beat_off[ADDR_W-1:0] : '0;
  assign o_mem_wdata = beat ? beat_wdata : '0;
  assign o_mem_wstrb = beat ? beat_wstrb : '0;

  assign wait_inc = (state == ARB_S_ARB) && i_b_valid && !b_ready;
  assign wait_clr = b_hs || !i_b_valid;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .inc          (wait_inc),
    .clr          (wait_clr),
    .at_max       (wait_at_max),
    .reaching_max (wait_reaching_max)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ARB_S_ARB;
      b_granted <= 1'b0;
    end else begin
      unique case (state)
        ARB_S_ARB: begin
          if (b_hs) begin
            if (i_b_lock) begin
              state     <= ARB_S_LOCK_B;
              b_granted <= 1'b1;
            end
          end else if (wait_at_max || wait_reaching_max) begin
            state     <= ARB_S_FORCE_B;
            b_granted <= 1'b1;
          end
        end
        ARB_S_FORCE_B: begin
          if (b_hs) begin
            state     <= i_b_lock ? ARB_S_LOCK_B : ARB_S_ARB;
            b_granted <= i_b_lock;
          end else if (!i_b_valid) begin
            state     <= ARB_S_ARB;
            b_granted <= 1'b0;
          end
        end
        ARB_S_LOCK_B: begin
          if (b_hs && !i_b_lock) begin
            state     <= ARB_S_ARB;
            b_granted <= 1'b0;
          end
        end
        default: begin
          state     <= ARB_S_ARB;
          b_granted <= 1'b0;
        end
      endcase
    end
  end

  // Reads and any out-of-range beat produce a response one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp <= '0;
    end else begin
      resp.valid <= beat && (!beat_we || !beat_in_range);
      resp.owner <= b_hs ? ARB_OWN_B : ARB_OWN_A;
      resp.read  <= !beat_we;
      resp.err   <= !beat_in_range;
    end
  end

  assign resp_a = resp.valid && (resp.owner == ARB_OWN_A);
  assign resp_b = resp.valid && (resp.owner == ARB_OWN_B);

  assign o_a_ready   = a_ready;
  assign o_b_ready   = b_ready;
  assign o_a_rvalid  = resp_a && resp.read;
  assign o_b_rvalid  = resp_b && resp.read;
  assign o_a_err     = resp_a && resp.err;
  assign o_b_err     = resp_b && resp.err;
  assign o_a_rdata   = (resp_a && resp.read && !resp.err) ? i_mem_rdata : '0;
  assign o_b_rdata   = (resp_b && resp.read && !resp.err) ? i_mem_rdata : '0;
  assign o_b_granted = b_granted;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural arbitration/memory model.
// A memory stub serves the DUT; a separate reference memory feeds the expected data.
module tb_dmem_port_arbiter;

  localparam int     XLEN      = 32;
  localparam int     ADDR_W    = 32;
  localparam longint MEM_BASE  = 0;
  localparam longint MEM_BYTES = 4096;
  localparam int     MAX_WAIT  = 8;

  logic        clk, rst_n;
  logic        a_valid, a_we, b_valid, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_wstrb, b_wstrb;
  logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en, mem_we, b_granted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  dmem_port_arbiter #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_BASE(32'h0), .MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_wstrb(a_wstrb),
    .o_a_ready(a_ready), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata), .o_a_err(a_err),
    .i_b_valid(b_valid), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_wstrb(b_wstrb),
    .i_b_lock(b_lock),
    .o_b_ready(b_ready), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata), .o_b_err(b_err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata), .o_b_granted(b_granted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub standing in for the data memory instance.
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | i;
    mem[4] <= 32'hDEAD_BEEF;
    mem[8] <= 32'h1122_3344;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_wstrb[k]) mem[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[11:2]];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_err = 0;
  int n_checks = 0;

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  bit          m_slot, m_locked, m_a_hs, m_b_hs;
  int          m_wait;
  bit          p_valid, p_owner_b, p_read, p_err;
  logic [31:0] p_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a >= MEM_BASE) && (a - MEM_BASE < MEM_BYTES);
  endfunction

  task automatic model_reset();
    m_slot = 0; m_locked = 0; m_wait = 0; m_a_hs = 0; m_b_hs = 0;
    p_valid = 0; p_owner_b = 0; p_read = 0; p_err = 0; p_data = '0;
  endtask

  task automatic model_compare();
    bit          e_a_ready, e_b_ready, e_en, we, ra, rb;
    logic [31:0] addr, wd;
    logic [3:0]  ws;
    e_a_ready = !(m_slot || m_locked);
    e_b_ready = (m_slot || m_locked) ? 1'b1 : (b_valid && !a_valid);
    m_a_hs = a_valid && e_a_ready;
    m_b_hs = b_valid && e_b_ready;
    addr = m_b_hs ? b_addr : a_addr;
    we   = m_b_hs ? b_we : a_we;
    wd   = m_b_hs ? b_wdata : a_wdata;
    ws   = m_b_hs ? b_wstrb : a_wstrb;
    e_en = (m_a_hs || m_b_hs) && in_rng(addr);
    chk("a_ready", 64'(a_ready), 64'(e_a_ready));
    chk("b_ready", 64'(b_ready), 64'(e_b_ready));
    chk("b_granted", 64'(b_granted), 64'(m_slot || m_locked));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    if (e_en) begin
      chk("mem_we", 64'(mem_we), 64'(we));
      chk("mem_addr", 64'(mem_addr), 64'(longint'(addr) - MEM_BASE));
      if (we) begin
        chk("mem_wdata", 64'(mem_wdata), 64'(wd));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(ws));
      end
    end
    ra = p_valid && !p_owner_b && p_read;
    rb = p_valid && p_owner_b && p_read;
    chk("a_rvalid", 64'(a_rvalid), 64'(ra));
    chk("a_err", 64'(a_err), 64'(p_valid && !p_owner_b && p_err));
    chk("a_rdata", 64'(a_rdata), 64'(ra ? p_data : 32'h0));
    chk("b_rvalid", 64'(b_rvalid), 64'(rb));
    chk("b_err", 64'(b_err), 64'(p_valid && p_owner_b && p_err));
    chk("b_rdata", 64'(b_rdata), 64'(rb ? p_data : 32'h0));
  endtask

  task automatic model_update();
    bit          beat, we, rng;
    logic [31:0] addr, wd;
    logic [3:0]  ws;
    int          idx;
    beat = m_a_hs || m_b_hs;
    addr = m_b_hs ? b_addr : a_addr;
    we   = m_b_hs ? b_we : a_we;
    wd   = m_b_hs ? b_wdata : a_wdata;
    ws   = m_b_hs ? b_wstrb : a_wstrb;
    rng  = in_rng(addr);
    idx  = int'((longint'(addr) - MEM_BASE) / 4);
    p_valid   = beat && (!we || !rng);
    p_owner_b = m_b_hs;
    p_read    = !we;
    p_err     = !rng;
    p_data    = (beat && rng && !we) ? ref_mem[idx] : 32'h0;
    if (beat && rng && we)
      for (int k = 0; k < 4; k++)
        if (ws[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
    if (m_b_hs) begin
      m_wait = 0; m_slot = 0; m_locked = b_lock;
    end else if (!b_valid) begin
      m_wait = 0; m_slot = 0;
    end else if (!m_slot && !m_locked) begin
      if (m_wait < MAX_WAIT) m_wait++;
      if (m_wait == MAX_WAIT) m_slot = 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (rst_n) model_compare();
  endtask

  task automatic adv();
    if (rst_n) model_update(); else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic drive_a(input bit v, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
    a_valid = v; a_we = we; a_addr = addr; a_wdata = wd; a_wstrb = ws;
  endtask

  task automatic drive_b(input bit v, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input bit lock);
    b_valid = v; b_we = we; b_addr = addr; b_wdata = wd; b_wstrb = ws; b_lock = lock;
  endtask

  initial begin
    int a_wins, gcyc, beat_n, done_at;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h5A00_0000 | i;
    ref_mem[4] = 32'hDEAD_BEEF;
    ref_mem[8] = 32'h1122_3344;
    model_reset();
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_rvalid", 64'({a_rvalid, b_rvalid, a_err, b_err}), 64'd0);
    chk("rst_granted", 64'(b_granted), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick();

    // A reads 0x10
    drive_a(1, 0, 32'h10, 0, 0);
    settle();
    chk("t1_a_ready", 64'(a_ready), 64'd1);
    chk("t1_mem_en", 64'(mem_en), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h10);
    adv();
    drive_a(0, 0, 0, 0, 0);
    settle();
    chk("t1_a_rvalid", 64'(a_rvalid), 64'd1);
    chk("t1_a_rdata", 64'(a_rdata), 64'hDEAD_BEEF);
    chk("t1_b_rvalid", 64'(b_rvalid), 64'd0);
    adv();

    // Partial write then immediate read-back
    drive_a(1, 1, 32'h20, 32'h0000_ABCD, 4'h3);
    tick();
    drive_a(1, 0, 32'h20, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    settle();
    chk("t6_rdata", 64'(a_rdata), 64'h1122_ABCD);
    adv();

    // B out-of-range write, then out-of-range read, then in-range read
    drive_b(1, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
    settle();
    chk("t3_mem_en", 64'(mem_en), 64'd0);
    chk("t3_b_ready", 64'(b_ready), 64'd1);
    adv();
    drive_b(1, 0, 32'h1004, 0, 0, 0);
    settle();
    chk("t3_b_err", 64'(b_err), 64'd1);
    chk("t3_b_rvalid", 64'(b_rvalid), 64'd0);
    adv();
    drive_b(1, 0, 32'h10, 0, 0, 0);
    settle();
    chk("t3_rd_err", 64'(b_err), 64'd1);
    chk("t3_rd_rvalid", 64'(b_rvalid), 64'd1);
    chk("t3_rd_rdata", 64'(b_rdata), 64'd0);
    adv();
    drive_b(0, 0, 0, 0, 0, 0);
    tick();

    // Contention: A wins MAX_WAIT cycles, then one forced B slot
    a_wins = 0; gcyc = -1;
    drive_b(1, 0, 32'h10, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive_a(1, 0, 32'h0 + 4 * i, 0, 0);
      settle();
      if (gcyc < 0 && b_granted) gcyc = i;
      else if (gcyc < 0 && a_ready) a_wins++;
      if (gcyc >= 0 && i == gcyc + 1) chk("t2_a_resume", 64'(a_ready), 64'd1);
      adv();
    end
    chk("t2_a_wins", 64'(a_wins), 64'd8);
    chk("t2_grant_cycle", 64'(gcyc), 64'd8);
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Locked 4-beat B burst against a continuously requesting A
    beat_n = 0; done_at = -1;
    drive_a(1, 0, 32'h10, 0, 0);
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      drive_b(1, 1, 32'h100 + 4 * beat_n, 32'hC0DE_0000 + beat_n, 4'hF, beat_n < 3);
      settle();
      if (m_b_hs) begin
        chk("t4_a_held", 64'(a_ready), 64'd0);
        beat_n++;
        if (beat_n == 4) done_at = i;
      end
      adv();
    end
    if (done_at < 0) begin
      n_checks++; n_err++;
      $display("FAIL t4_timeout: got %0d beats want 4", beat_n);
    end
    drive_b(0, 0, 0, 0, 0, 0);
    settle();
    chk("t4_a_accept", 64'(a_ready && a_valid), 64'd1);
    adv();
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 0, 32'h100 + 4 * i, 0, 0);
      tick();
    end
    drive_a(0, 0, 0, 0, 0);
    settle();
    chk("t4_last_rdata", 64'(a_rdata), 64'hC0DE_0003);
    adv();

    // Reset pulse between acceptance and response
    drive_a(1, 0, 32'h10, 0, 0);
    settle();
    #2 rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    model_reset();
    adv();
    settle();
    chk("t5_no_rvalid", 64'(a_rvalid), 64'd0);
    chk("t5_a_ready", 64'(a_ready), 64'd1);
    chk("t5_granted", 64'(b_granted), 64'd0);
    adv();

    // Mixed traffic, including A out-of-range accesses
    for (int i = 0; i < 24; i++) begin
      drive_a((i % 3) != 0, (i % 4) == 1, ((i % 5) == 4) ? 32'h2000 : 32'h10 + 4 * (i % 6),
              32'h0101_0000 * i + i, 4'(i % 16));
      drive_b((i % 2) == 1, (i % 3) == 2, 32'h20 + 4 * (i % 4), 32'hB0B0_0000 + i, 4'hC, 0);
      tick();
    end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory between two requesters. Port A is the pipeline MEM stage and has priority. Port B is a debug/dump master used for memory inspection and program loading. The block sits between those requesters and the data memory instance: it grants one access per cycle, routes the read response back to its owner one cycle later, flags out-of-range accesses, and prevents port B starvation.

Parameters:
XLEN, 32, data width in bits (32 or 64)
ADDR_W, 32, byte address width
MEM_BASE, 32'h0, first byte address of data memory
MEM_BYTES, 4096, data memory size in bytes
MAX_WAIT, 8, cycles B may wait before a forced B slot (range 1..255)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_a_valid  in  1  A request valid
i_a_we  in  1  A write (1) / read (0)
i_a_addr  in  ADDR_W  A byte address
i_a_wdata  in  XLEN  A write data
i_a_wstrb  in  XLEN/8  A byte enables
o_a_ready  out  1  A request accepted this cycle when valid
o_a_rvalid  out  1  A read response pulse
o_a_rdata  out  XLEN  A read data
o_a_err  out  1  A out-of-range pulse
i_b_valid, i_b_we, i_b_addr, i_b_wdata, i_b_wstrb  in  same widths as the A inputs  B request
i_b_lock  in  1  keep B grant after this beat
o_b_ready, o_b_rvalid, o_b_rdata, o_b_err  out  same widths as the A outputs  B response
o_mem_en  out  1  memory access enable
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  address minus MEM_BASE
o_mem_wdata  out  XLEN  write data
o_mem_wstrb  out  XLEN/8  byte enables
i_mem_rdata  in  XLEN  synchronous read data, valid one cycle after o_mem_en
o_b_granted  out  1  state is FORCE_B or LOCK_B

Behaviour:
- Reset:
  - State ARB; wait counter 0; pending response cleared.
  - All o_* are 0 except o_a_ready, which is 1.
  - Reset asserted mid-transaction drops any pending response; no rvalid is emitted afterwards.
- Handshake: a beat is accepted when valid && ready. Memory signals are driven combinationally from the accepted beat in the same cycle.
- In-range test: MEM_BASE <= addr < MEM_BASE+MEM_BYTES.
  - Out-of-range beats are still accepted, but o_mem_en stays 0.
  - Next cycle the owner gets err=1 and rvalid=1 for a read (rdata=0), or err=1 only for a write.
- Reads: owner rvalid=1 for exactly one cycle, the cycle after acceptance, with rdata = i_mem_rdata. The non-owner's rdata is 0.
- Writes: no response pulse unless there is an error.
- No response backpressure. Back-to-back beats are legal every cycle.
- States:
  - ARB:
    - o_a_ready=1; o_b_ready = !i_a_valid, so A wins any simultaneous request.
    - If the wait counter == MAX_WAIT, go to FORCE_B.
    - A B handshake with i_b_lock=1 goes to LOCK_B.
  - FORCE_B:
    - o_a_ready=0, o_b_ready=1.
    - On a B handshake: counter←0; go to LOCK_B if i_b_lock, else ARB.
    - If i_b_valid drops before any handshake: counter←0, go to ARB.
  - LOCK_B:
    - o_a_ready=0, o_b_ready=1.
    - Stay until a B handshake with i_b_lock=0, then go to ARB.
    - A requests are held off indefinitely (the pipeline stalls on !o_a_ready).
- Wait counter (8-bit):
  - +1 each cycle in ARB with i_b_valid && !o_b_ready; saturates at MAX_WAIT.
  - Cleared on any B handshake, or when i_b_valid=0.
- o_mem_addr = addr − MEM_BASE, truncated to ADDR_W. Widths never wrap into range.

Decomposition:
- Constants.vh holds:
  - State encodings ARB_S_ARB=2'd0, ARB_S_FORCE_B=2'd1, ARB_S_LOCK_B=2'd2.
  - Owner codes ARB_OWN_A=1'b0, ARB_OWN_B=1'b1.
- One sub-module, arb_wait_counter: saturating counter with inc/clr inputs and an at_max output, parameterised by MAX_WAIT.
- Range check and response routing stay inline.

Test Plan:
1. After reset, A reads 0x10 in cycle 1 while memory holds 0xDEADBEEF there → o_a_ready=1, o_mem_en=1, o_mem_addr=0x10; next cycle o_a_rvalid=1, o_a_rdata=0xDEADBEEF, o_b_rvalid=0.
2. A and B valid together every cycle, MAX_WAIT=8 → A wins 8 cycles, cycle 9 o_a_ready=0, B beat issued, o_b_granted=1; cycle 10 A resumes.
3. B writes 0x1000 (MEM_BYTES=4096) with wstrb=4'hF → o_mem_en=0, next cycle o_b_err=1, o_b_rvalid=0; memory unchanged.
4. B does a 4-beat burst with lock=1,1,1,0 while A is valid → o_a_ready=0 for all 4 beats, then A accepted the cycle after beat 4.
5. A issues a read, and i_rst_n pulses low before the next edge → no o_a_rvalid afterwards, state ARB, o_a_ready=1.
6. A write then an immediate read of the same address, wstrb=4'h3, data 0x0000ABCD over prior 0x11223344 → read returns 0x1122ABCD.
